fpu_ret_collect: RTL

Retirement-side collector for the three FPU/SIMD store-unit issue ports (u1, u3, u5). It accepts up to three completion tokens per cycle (14-bit `ret` tag, `ret_en` strobe, 6-bit FP exception flags), packs them in port order into a circular buffer, and drains one token per cycle to the retire logic over a valid/ready handshake. It raises a stall toward the scheduler when the buffer cannot absorb a full three-token burst, and keeps optional sticky FP exception flags for the fpcsr.

---
 rtl/fpu_ret_collect.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fpu_ret_collect.sv
// rtl/fpu_ret_collect.sv - FPU/SIMD store-port completion collector with circular buffer
//
// Accepts up to three completion tokens per cycle from issue ports u1/u3/u5,
// packs them in port order into a DEPTH-entry circular buffer, and drains one
// token per cycle over a valid/ready handshake.
//
// Optional feature macro: FPRET_STICKY_EN (sticky FP exception flag register
// and flags_clr). When undefined, fpflags_sticky is tied to 0.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   u1_ret/u3_ret/u5_ret  [13:0]  completion tags
//   u1_ret_en/u3_ret_en/u5_ret_en tag-valid strobes
//   FOOFL0/FOOFL1/FOOFL2  [5:0]   exception flags for u1/u3/u5
//   out_ret [13:0], out_flags [5:0], out_vld, out_rdy   head token handshake
//   stall                         fewer than 3 free entries
//   ovf                           sticky overflow (cleared only by rst)
//   flags_clr                     clears sticky flags
//   fpflags_sticky [5:0]          OR of accepted flags since last clear

module fpu_ret_collect #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] u1_ret,
    input  logic [13:0] u3_ret,
    input  logic [13:0] u5_ret,
    input  logic        u1_ret_en,
    input  logic        u3_ret_en,
    input  logic        u5_ret_en,
    input  logic [5:0]  FOOFL0,
    input  logic [5:0]  FOOFL1,
    input  logic [5:0]  FOOFL2,
    output logic [13:0] out_ret,
    output logic [5:0]  out_flags,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic        stall,
    output logic        ovf,
    input  logic        flags_clr,
    output logic [5:0]  fpflags_sticky
);

    localparam int AW = $clog2(DEPTH);

    logic [19:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [AW:0]   free;
    logic [AW:0]   n_str;
    logic [1:0]    pos3;
    logic [1:0]    pos5;
    logic          acc1;
    logic          acc3;
    logic          acc5;
    logic [1:0]    accepted;
    logic [5:0]    acc_flags;
    logic          deq;
    logic          drop;

    // Slot offsets compact the strobes so an idle port leaves no hole.
    // Free space comes from the registered count only; a same-cycle
    // dequeue never makes room for an incoming token.
    always_comb begin
        free      = (AW+1)'(DEPTH) - count;
        n_str     = (AW+1)'(u1_ret_en) + (AW+1)'(u3_ret_en) + (AW+1)'(u5_ret_en);
        pos3      = {1'b0, u1_ret_en};
        pos5      = pos3 + {1'b0, u3_ret_en};
        acc1      = u1_ret_en && (free != '0);
        acc3      = u3_ret_en && ((AW+1)'(pos3) < free);
        acc5      = u5_ret_en && ((AW+1)'(pos5) < free);
        accepted  = {1'b0, acc1} + {1'b0, acc3} + {1'b0, acc5};
        acc_flags = (acc1 ? FOOFL0 : 6'h00) | (acc3 ? FOOFL1 : 6'h00)
                  | (acc5 ? FOOFL2 : 6'h00);
        deq       = out_vld & out_rdy;
        drop      = n_str > free;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (acc1) mem[wr_ptr]            <= {u1_ret, FOOFL0};
            if (acc3) mem[wr_ptr + AW'(pos3)] <= {u3_ret, FOOFL1};
            if (acc5) mem[wr_ptr + AW'(pos5)] <= {u5_ret, FOOFL2};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(accepted);
            if (deq) rd_ptr <= rd_ptr + AW'(1);
            count  <= count + (AW+1)'(accepted) - (AW+1)'(deq);
            if (drop) ovf <= 1'b1;
        end
    end

    assign out_vld   = (count != '0);
    assign out_ret   = mem[rd_ptr][19:6];
    assign out_flags = mem[rd_ptr][5:0];
    assign stall     = count > (AW+1)'(DEPTH - 3);

`ifdef FPRET_STICKY_EN
    logic [5:0] sticky_q;

    // Clear takes effect before this cycle's accepted flags are ORed in.
    always_ff @(posedge clk) begin
        if (rst) sticky_q <= 6'h00;
        else     sticky_q <= (flags_clr ? 6'h00 : sticky_q) | acc_flags;
    end

    assign fpflags_sticky = sticky_q;
`else
    logic unused_sticky_inputs;
    assign unused_sticky_inputs = flags_clr ^ (^acc_flags);
    assign fpflags_sticky       = 6'h00;
`endif

endmodule
